// File: rtl/mmm_final_sub.sv
// mmm_final_sub: final conditional subtraction of a word-serial Montgomery
// product. Collects result words S (LSW first) together with the matching
// modulus words M, computing S-M word by word with a borrow chain. When the
// frame ends, the block picks S-M if the (K+1)-bit result is >= M
// (top bit set or no final borrow), otherwise S. It then streams the chosen
// words out LSW first.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   S_IN, M_IN        result word / modulus word (W bits)
//   S_TOP             result bit K, sampled with S_LAST
//   S_VALID, S_LAST   input word valid / most significant word marker
//   S_READY           input accepted (IDLE / COLLECT only)
//   R_OUT, R_VALID    reduced output word / valid
//   R_LAST            final output word
//   R_READY           downstream ready
//   R_SUB             (MMM_FSUB_STATUS_EN only) 1 when the subtracted value is output
//
// Optional feature macro: MMM_FSUB_STATUS_EN adds the R_SUB status output.
module mmm_final_sub #(
  parameter int K = 1024,
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] S_IN,
  input  logic [W-1:0] M_IN,
  input  logic         S_TOP,
  input  logic         S_VALID,
  input  logic         S_LAST,
  output logic         S_READY,
  output logic [W-1:0] R_OUT,
  output logic         R_VALID,
  output logic         R_LAST,
  input  logic         R_READY
`ifdef MMM_FSUB_STATUS_EN
  ,
  output logic         R_SUB
`endif
);
  localparam int N  = K / W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
  state_t state, state_nxt;

  logic [IW-1:0] idx, last_idx, ld_idx;
  logic          borrow, sel;
  logic [W-1:0]  sb [N];
  logic [W-1:0]  db [N];
  logic          s_hs, r_hs, frame_end, b_in, b_out, ld;
  logic [W-1:0]  d, rd_word;

  assign S_READY   = (state != DRAIN);
  assign s_hs      = S_VALID & S_READY;
  assign r_hs      = R_VALID & R_READY;
  // borrow chain restarts at word 0 of every frame
  assign b_in      = (idx == '0) ? 1'b0 : borrow;
  assign {b_out, d} = {1'b0, S_IN} - {1'b0, M_IN} - {{W{1'b0}}, b_in};
  // a frame closes on S_LAST or when the buffer is full
  assign frame_end = s_hs & (S_LAST | (idx == IW'(N-1)));

  // Output register loads on the first DRAIN cycle (nothing valid yet) and
  // on every accepted non-final word; idx tracks the word held in R_OUT.
  assign ld      = (state == DRAIN) & (~R_VALID | (R_READY & ~R_LAST));
  assign ld_idx  = R_VALID ? idx + 1'b1 : idx;
  assign rd_word = sel ? db[ld_idx] : sb[ld_idx];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (s_hs) state_nxt = frame_end ? DRAIN : COLLECT;
      COLLECT: if (frame_end) state_nxt = DRAIN;
      DRAIN:   if (r_hs && R_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // word buffers carry no reset; a new frame overwrites what it uses
  always_ff @(posedge CLK) begin
    if (s_hs) begin
      sb[idx] <= S_IN;
      db[idx] <= d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= '0;
      last_idx <= '0;
      borrow   <= 1'b0;
      sel      <= 1'b0;
      R_OUT    <= '0;
      R_VALID  <= 1'b0;
      R_LAST   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (s_hs) begin
        borrow <= b_out;
        if (frame_end) begin
          sel      <= S_TOP | ~b_out;
          last_idx <= idx;
          idx      <= '0;
          borrow   <= 1'b0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (ld) begin
        R_OUT   <= rd_word;
        R_LAST  <= (ld_idx == last_idx);
        R_VALID <= 1'b1;
        idx     <= ld_idx;
      end else if (r_hs && R_LAST) begin
        R_VALID <= 1'b0;
        R_LAST  <= 1'b0;
        idx     <= '0;
      end
    end
  end

`ifdef MMM_FSUB_STATUS_EN
  always_ff @(posedge CLK) begin
    if (RST)     R_SUB <= 1'b0;
    else if (ld) R_SUB <= sel;
  end
`endif

endmodule

// File: tb/tb_mmm_final_sub.sv
module tb_mmm_final_sub;
  localparam int K = 64;
  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] S_IN, M_IN;
  logic         S_TOP, S_VALID, S_LAST, S_READY;
  logic [W-1:0] R_OUT;
  logic         R_VALID, R_LAST, R_READY;
`ifdef MMM_FSUB_STATUS_EN
  logic         R_SUB;
`endif

  mmm_final_sub #(.K(K), .W(W)) dut (
    .CLK(CLK), .RST(RST), .S_IN(S_IN), .M_IN(M_IN), .S_TOP(S_TOP),
    .S_VALID(S_VALID), .S_LAST(S_LAST), .S_READY(S_READY),
    .R_OUT(R_OUT), .R_VALID(R_VALID), .R_LAST(R_LAST), .R_READY(R_READY)
`ifdef MMM_FSUB_STATUS_EN
    , .R_SUB(R_SUB)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0][15:0] s, m, e;
    int               n;
    bit               lastf, top, sel;
  } vec_t;

  vec_t tab [7];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic [63:0] s, m, e, input int n,
                              input bit lastf, top, sel);
    vec_t v;
    v.s = s; v.m = m; v.e = e; v.n = n;
    v.lastf = lastf; v.top = top; v.sel = sel;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      @(negedge CLK);
      S_VALID = 1'b1;
      S_IN    = v.s[i];
      M_IN    = v.m[i];
      S_LAST  = v.lastf && (i == v.n - 1);
      S_TOP   = (i == v.n - 1) ? v.top : 1'b0;
      chk("s_ready_collect", S_READY, 1);
      @(posedge CLK);
    end
    #1;
    S_VALID = 1'b0; S_LAST = 1'b0; S_TOP = 1'b0;
  endtask

  // two negedges after the closing handshake: first still idle, second valid
  task automatic latency();
    @(negedge CLK); chk("lat_cycle1_rvalid", R_VALID, 0);
    @(negedge CLK); chk("lat_cycle2_rvalid", R_VALID, 1);
  endtask

  task automatic recv(input vec_t v, input logic [7:0] pat);
    int w = 0;
    for (int k = 0; k < 40 && w < v.n; k++) begin
      R_READY = pat[k % 8];
      if (R_VALID) begin
        chk("r_out", R_OUT, v.e[w]);
        chk("s_ready_drain", S_READY, 0);
`ifdef MMM_FSUB_STATUS_EN
        chk("r_sub", R_SUB, v.sel);
`endif
        if (R_READY) begin
          chk("r_last", R_LAST, (w == v.n - 1));
          w++;
        end
      end
      if (w < v.n) @(negedge CLK);
    end
    chk("word_count", w, v.n);
    @(negedge CLK);
    chk("r_valid_after_last", R_VALID, 0);
    chk("s_ready_after_last", S_READY, 1);
    R_READY = 1'b1;
  endtask

  initial begin
    tab[0] = mk(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0002, 4, 1, 0, 1);
    tab[1] = mk(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0001, 4, 1, 0, 0);
    tab[2] = mk(64'h0001_0001_0001_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0001_0001_0001_0002, 4, 1, 1, 1);
    // closes on the word count alone (no S_LAST); borrow ripples into word 1
    tab[3] = mk(64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_FFFF, 4, 0, 0, 1);
    tab[4] = mk(64'h0000_0000_0009_0007, 64'h0000_0000_0002_0008, 64'h0000_0000_0006_FFFF, 2, 1, 0, 1);
    // single word, borrow out -> S passed through
    tab[5] = mk(64'h0000_0000_0000_0004, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0004, 1, 1, 0, 0);
    tab[6] = mk(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_0000, 4, 1, 0, 1);

    RST = 1'b1; S_IN = '0; M_IN = '0; S_TOP = 1'b0; S_VALID = 1'b0; S_LAST = 1'b0;
    R_READY = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_r_valid", R_VALID, 0);
    chk("rst_r_last", R_LAST, 0);
    chk("rst_r_out", R_OUT, 0);
`ifdef MMM_FSUB_STATUS_EN
    chk("rst_r_sub", R_SUB, 0);
`endif
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_s_ready", S_READY, 1);

    for (int i = 0; i < 6; i++) begin
      send(tab[i]);
      latency();
      recv(tab[i], 8'hFF);
    end

    // back-pressure: ready 1,0,0,1 then 1s; input noise during drain is ignored
    send(tab[6]);
    S_VALID = 1'b1; S_IN = 16'hFFFF; M_IN = 16'h0001; S_LAST = 1'b1;
    latency();
    recv(tab[6], 8'b1111_1001);
    S_VALID = 1'b0; S_LAST = 1'b0;

    // 2-word frame, then a second frame abandoned by reset mid-drain
    send(tab[4]);
    latency();
    recv(tab[4], 8'hFF);
    send(tab[0]);
    latency();
    R_READY = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("midrst_r_valid", R_VALID, 0);
    chk("midrst_r_last", R_LAST, 0);
    chk("midrst_r_out", R_OUT, 0);
    chk("midrst_s_ready", S_READY, 1);
    R_READY = 1'b1;
    send(tab[1]);
    latency();
    recv(tab[1], 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
